// File: rtl/draw_pkg.sv
// Shared constants and types for the 160x120, 9-bit-colour VGA car map:
// coordinate widths, erase background colour and the frame scheduler state encoding.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int DIR_W = 3;
  localparam int COL_W = 9;

  // Colour the drawer paints when a command has eng_erase set.
  localparam logic [COL_W-1:0] BG_COLOUR = 9'h000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_E_ISSUE = 3'd1,
    S_E_WAIT  = 3'd2,
    S_D_ISSUE = 3'd3,
    S_D_WAIT  = 3'd4,
    S_FINISH  = 3'd5
  } sched_state_t;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [DIR_W-1:0] dir;
  } car_pos_t;

endpackage

// File: rtl/draw_watchdog.sv
// Wait-state watchdog: counts enabled cycles since the last clear.
// o_expired is combinational and marks the TIMEOUT_CYCLES-th enabled cycle.
module draw_watchdog #(
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_expired = i_en && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/car_frame_scheduler.sv
// Per-frame sprite sequencer: snapshots cars on frame_tick, erases old positions, then draws new ones.
// First eng_start 2+ cycles after the tick (one extra per skipped slot); one command outstanding, advanced by eng_done or watchdog.
module car_frame_scheduler
  import draw_pkg::*;
#(
  parameter int NUM_CARS       = 2,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      frame_tick,
  input  logic [NUM_CARS*X_W-1:0]   car_x,
  input  logic [NUM_CARS*Y_W-1:0]   car_y,
  input  logic [NUM_CARS*DIR_W-1:0] car_dir,
  input  logic [NUM_CARS-1:0]       car_valid,
  output logic                      eng_start,
  output logic [X_W-1:0]            eng_x,
  output logic [Y_W-1:0]            eng_y,
  output logic [DIR_W-1:0]          eng_dir,
  output logic                      eng_erase,
  input  logic                      eng_done,
  output logic                      frame_busy,
  output logic                      frame_done,
  output logic                      overrun,
  output logic                      timeout_err
);

  localparam int               IDX_W    = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);

  sched_state_t                  r_state;
  logic [IDX_W-1:0]              r_idx;
  logic [NUM_CARS-1:0]           r_new_valid;
  logic [NUM_CARS-1:0]           r_prev_valid;
  car_pos_t [NUM_CARS-1:0]       r_new;
  car_pos_t [NUM_CARS-1:0]       r_prev;

  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_expired;
  logic w_wait_over;
  logic w_last;

  assign w_wd_clr    = (r_state == S_E_ISSUE) || (r_state == S_D_ISSUE);
  assign w_wd_en     = (r_state == S_E_WAIT)  || (r_state == S_D_WAIT);
  assign w_wait_over = eng_done || w_wd_expired;
  assign w_last      = (r_idx == LAST_IDX);

  draw_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .resetn   (resetn),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expired(w_wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_new_valid  <= '0;
      r_prev_valid <= '0;
      r_new        <= '0;
      r_prev       <= '0;
      eng_start    <= 1'b0;
      eng_x        <= '0;
      eng_y        <= '0;
      eng_dir      <= '0;
      eng_erase    <= 1'b0;
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      eng_start  <= 1'b0;
      frame_done <= 1'b0;
      // Ticks are honoured only from IDLE; anywhere else they are flagged and dropped.
      if (frame_tick && (r_state != S_IDLE)) begin
        overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          frame_busy <= frame_tick;
          if (frame_tick) begin
            for (int i = 0; i < NUM_CARS; i++) begin
              r_new[i].x   <= car_x[i*X_W +: X_W];
              r_new[i].y   <= car_y[i*Y_W +: Y_W];
              r_new[i].dir <= car_dir[i*DIR_W +: DIR_W];
            end
            r_new_valid <= car_valid;
            r_idx       <= '0;
            r_state     <= S_E_ISSUE;
          end
        end

        S_E_ISSUE: begin
          if (r_prev_valid[r_idx]) begin
            eng_start <= 1'b1;
            eng_x     <= r_prev[r_idx].x;
            eng_y     <= r_prev[r_idx].y;
            eng_dir   <= r_prev[r_idx].dir;
            eng_erase <= 1'b1;
            r_state   <= S_E_WAIT;
          end else if (w_last) begin
            r_idx   <= '0;
            r_state <= S_D_ISSUE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_E_WAIT: begin
          if (w_wait_over) begin
            if (!eng_done) begin
              timeout_err <= 1'b1;
            end
            if (w_last) begin
              r_idx   <= '0;
              r_state <= S_D_ISSUE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_E_ISSUE;
            end
          end
        end

        S_D_ISSUE: begin
          if (r_new_valid[r_idx]) begin
            eng_start <= 1'b1;
            eng_x     <= r_new[r_idx].x;
            eng_y     <= r_new[r_idx].y;
            eng_dir   <= r_new[r_idx].dir;
            eng_erase <= 1'b0;
            r_state   <= S_D_WAIT;
          end else if (w_last) begin
            r_state <= S_FINISH;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_D_WAIT: begin
          if (w_wait_over) begin
            if (!eng_done) begin
              timeout_err <= 1'b1;
            end
            if (w_last) begin
              r_state <= S_FINISH;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_D_ISSUE;
            end
          end
        end

        S_FINISH: begin
          r_prev       <= r_new;
          r_prev_valid <= r_new_valid;
          r_idx        <= '0;
          frame_done   <= 1'b1;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_car_frame_scheduler.sv
// Directed frames for car_frame_scheduler, checked every cycle against an expected-command-list model
// plus hand-computed latencies and command literals.
module tb_car_frame_scheduler;

  localparam int NC = 2;
  localparam int TO = 512;

  logic            clk = 1'b0;
  logic            resetn;
  logic            frame_tick;
  logic [NC*8-1:0] car_x;
  logic [NC*7-1:0] car_y;
  logic [NC*3-1:0] car_dir;
  logic [NC-1:0]   car_valid;
  logic            eng_start;
  logic [7:0]      eng_x;
  logic [6:0]      eng_y;
  logic [2:0]      eng_dir;
  logic            eng_erase;
  logic            eng_done;
  logic            frame_busy;
  logic            frame_done;
  logic            overrun;
  logic            timeout_err;

  car_frame_scheduler #(
    .NUM_CARS      (NC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .car_x      (car_x),
    .car_y      (car_y),
    .car_dir    (car_dir),
    .car_valid  (car_valid),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_dir    (eng_dir),
    .eng_erase  (eng_erase),
    .eng_done   (eng_done),
    .frame_busy (frame_busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: commands still owed by the current frame, and the positions drawn last frame.
  logic [18:0]   exp_q[$];
  logic [18:0]   obs_q[$];
  int            obs_cyc_q[$];
  logic [17:0]   m_prev [NC];
  logic [NC-1:0] m_prev_valid;
  bit            frame_active;
  int            tick_cyc;
  int            drw_delay = 4;
  int            n_starts = 0;
  int            n_erases = 0;
  int            n_done = 0;
  int            done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_prev_valid = '0;
    for (int i = 0; i < NC; i++) m_prev[i] = '0;
    frame_active = 1'b0;
  endtask

  task automatic model_frame();
    for (int i = 0; i < NC; i++)
      if (m_prev_valid[i]) exp_q.push_back({m_prev[i], 1'b1});
    for (int i = 0; i < NC; i++)
      if (car_valid[i]) exp_q.push_back({car_x[i*8 +: 8], car_y[i*7 +: 7], car_dir[i*3 +: 3], 1'b0});
    for (int i = 0; i < NC; i++) m_prev[i] = {car_x[i*8 +: 8], car_y[i*7 +: 7], car_dir[i*3 +: 3]};
    m_prev_valid = car_valid;
    frame_active = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_car(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] d, input logic v);
    car_x[i*8 +: 8]   = x;
    car_y[i*7 +: 7]   = y;
    car_dir[i*3 +: 3] = d;
    car_valid[i]      = v;
  endtask

  task automatic do_tick(input bit accept);
    step();
    frame_tick = 1'b1;
    if (accept) begin
      model_frame();
      tick_cyc = cyc;
    end
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int i;
    d0 = n_done;
    i  = 0;
    while (n_done == d0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk(name, 32'(n_done - d0), 32'd1);
  endtask

  // Drawer: answers each command eng_done drw_delay cycles after eng_start; negative delay never answers.
  initial begin
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn && eng_start && drw_delay >= 0) begin
        repeat (drw_delay) @(posedge clk);
        #1 eng_done = 1'b1;
        @(posedge clk);
        #1 eng_done = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    bit          outst;
    int          wait_n;
    logic [18:0] held;
    logic [18:0] cur;
    outst  = 1'b0;
    wait_n = 0;
    held   = '0;
    forever begin
      @(negedge clk);
      cur = {eng_x, eng_y, eng_dir, eng_erase};
      if (!resetn) begin
        outst = 1'b0;
      end else begin
        if (eng_start) begin
          chk("start_while_outstanding", 32'(outst), 32'd0);
          chk("start_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) chk("cmd", 32'(cur), 32'(exp_q.pop_front()));
          obs_q.push_back(cur);
          obs_cyc_q.push_back(cyc);
          held   = cur;
          outst  = 1'b1;
          wait_n = 1;
          n_starts++;
          if (eng_erase) n_erases++;
        end else if (outst) begin
          chk("cmd_hold_stable", 32'(cur), 32'(held));
          wait_n++;
          if (eng_done || wait_n >= TO) outst = 1'b0;
        end
        if (frame_done) begin
          chk("done_expected", 32'(frame_active), 32'd1);
          chk("done_all_cmds_issued", 32'(exp_q.size()), 32'd0);
          chk("done_none_outstanding", 32'(outst), 32'd0);
          chk("busy_at_done", 32'(frame_busy), 32'd1);
          frame_active = 1'b0;
          n_done++;
          done_cyc = cyc;
        end else if (frame_active) begin
          if (cyc > tick_cyc) chk("busy_high", 32'(frame_busy), 32'd1);
        end else begin
          chk("busy_low", 32'(frame_busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got cycle %0d, expected finish", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int base;
    int s0;
    int e0;
    int s;
    int i;
    resetn     = 1'b0;
    frame_tick = 1'b0;
    car_x      = '0;
    car_y      = '0;
    car_dir    = '0;
    car_valid  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({eng_start, eng_x, eng_y, eng_dir, eng_erase, frame_busy, frame_done, overrun, timeout_err}), 32'd0);
    step();
    resetn = 1'b1;

    // 1: first frame, one car, no erases.
    drw_delay = 113;
    set_car(0, 8'd10, 7'd20, 3'd0, 1'b1);
    set_car(1, 8'd0, 7'd0, 3'd0, 1'b0);
    base = obs_q.size();
    s0   = n_starts;
    do_tick(1'b1);
    wait_done("t1_frame_done", 2000);
    chk("t1_start_count", 32'(n_starts - s0), 32'd1);
    chk("t1_cmd", 32'(obs_q[base]), 32'({8'd10, 7'd20, 3'd0, 1'b0}));
    chk("t1_start_latency", 32'(obs_cyc_q[base] - tick_cyc), 32'd4);
    chk("t1_done_latency", 32'(done_cyc - obs_cyc_q[base]), 32'd116);
    @(negedge clk);
    chk("t1_busy_low_after", 32'(frame_busy), 32'd0);

    // 2: erase car0 at old spot, then draw both.
    drw_delay = 3;
    set_car(0, 8'd11, 7'd20, 3'd1, 1'b1);
    set_car(1, 8'd50, 7'd60, 3'd2, 1'b1);
    base = obs_q.size();
    s0   = n_starts;
    e0   = n_erases;
    do_tick(1'b1);
    wait_done("t2_frame_done", 2000);
    chk("t2_start_count", 32'(n_starts - s0), 32'd3);
    chk("t2_erase_count", 32'(n_erases - e0), 32'd1);
    chk("t2_cmd0", 32'(obs_q[base]),     32'({8'd10, 7'd20, 3'd0, 1'b1}));
    chk("t2_cmd1", 32'(obs_q[base + 1]), 32'({8'd11, 7'd20, 3'd1, 1'b0}));
    chk("t2_cmd2", 32'(obs_q[base + 2]), 32'({8'd50, 7'd60, 3'd2, 1'b0}));

    // 3: extra tick while a draw is outstanding.
    drw_delay = 20;
    set_car(0, 8'd12, 7'd21, 3'd1, 1'b1);
    base = obs_q.size();
    s0   = n_starts;
    do_tick(1'b1);
    i = 0;
    while (obs_q.size() < base + 3 && i < 500) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("t3_in_first_draw", 32'(obs_q.size() - base), 32'd3);
    do_tick(1'b0);
    wait_done("t3_frame_done", 2000);
    chk("t3_overrun", 32'(overrun), 32'd1);
    chk("t3_start_count", 32'(n_starts - s0), 32'd4);
    chk("t3_last_cmd", 32'(obs_q[base + 3]), 32'({8'd50, 7'd60, 3'd2, 1'b0}));
    repeat (30) @(negedge clk);
    chk("t3_no_extra_frame", 32'(n_starts - s0), 32'd4);
    chk("t3_overrun_sticky", 32'(overrun), 32'd1);

    // 4: drawer silent, watchdog forces progress.
    drw_delay = -1;
    set_car(0, 8'd5, 7'd6, 3'd7, 1'b1);
    set_car(1, 8'd0, 7'd0, 3'd0, 1'b0);
    base = obs_q.size();
    s0   = n_starts;
    do_tick(1'b1);
    i = 0;
    while (obs_q.size() <= base && i < 100) begin
      @(posedge clk);
      i++;
    end
    s = obs_cyc_q[base];
    while (cyc < s + 511) @(negedge clk);
    chk("t4_timeout_not_early", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("t4_timeout_set", 32'(timeout_err), 32'd1);
    wait_done("t4_frame_done", 3000);
    chk("t4_start_count", 32'(n_starts - s0), 32'd3);
    chk("t4_next_start_cycle", 32'(obs_cyc_q[base + 1] - s), 32'd513);
    chk("t4_cmd0", 32'(obs_q[base]), 32'({8'd12, 7'd21, 3'd1, 1'b1}));
    chk("t4_timeout_sticky", 32'(timeout_err), 32'd1);

    // 5: reset in E_WAIT, then a clean frame draws only.
    set_car(0, 8'd30, 7'd40, 3'd3, 1'b1);
    set_car(1, 8'd70, 7'd80, 3'd5, 1'b1);
    base = obs_q.size();
    do_tick(1'b1);
    i = 0;
    while (obs_q.size() <= base && i < 100) begin
      @(posedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    step();
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("t5_reset_outputs", 32'({eng_start, eng_x, eng_y, eng_dir, eng_erase, frame_busy, frame_done, overrun, timeout_err}), 32'd0);
    step();
    resetn    = 1'b1;
    drw_delay = 4;
    base = obs_q.size();
    s0   = n_starts;
    e0   = n_erases;
    do_tick(1'b1);
    wait_done("t5_frame_done", 2000);
    chk("t5_start_count", 32'(n_starts - s0), 32'd2);
    chk("t5_no_erases", 32'(n_erases - e0), 32'd0);
    chk("t5_cmd0", 32'(obs_q[base]),     32'({8'd30, 7'd40, 3'd3, 1'b0}));
    chk("t5_cmd1", 32'(obs_q[base + 1]), 32'({8'd70, 7'd80, 3'd5, 1'b0}));

    // 6: inputs change after the tick; snapshot must be used.
    set_car(0, 8'd10, 7'd20, 3'd4, 1'b1);
    set_car(1, 8'd0, 7'd0, 3'd0, 1'b0);
    base = obs_q.size();
    s0   = n_starts;
    do_tick(1'b1);
    car_x[7:0] = 8'd99;
    wait_done("t6_frame_done", 2000);
    chk("t6_start_count", 32'(n_starts - s0), 32'd3);
    chk("t6_draw_uses_snapshot", 32'(obs_q[base + 2]), 32'({8'd10, 7'd20, 3'd4, 1'b0}));

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
